// File: rtl/downcount_drain.sv
// Loadable WIDTH-bit down-counter that drains a loaded budget by unit decrements
// or variable subtractions. Build with DOWNCOUNT_SATURATE_EN to clamp q at 0 on underflow.
module downcount_drain #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             sub,
  input  logic [WIDTH-1:0] step,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             borrow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       r_state, w_state_nx;
  logic [WIDTH-1:0] r_q, w_q_nx;
  logic             r_borrow, w_borrow_nx;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_dec;

  // Extra MSB of the widened difference is the borrow out of q - step.
  assign w_diff = {1'b0, r_q} - {1'b0, step};
  assign w_dec  = r_q - ONE;

  always_comb begin
    w_state_nx  = r_state;
    w_q_nx      = r_q;
    w_borrow_nx = r_borrow;
    if (load) begin
      w_q_nx      = d;
      w_borrow_nx = 1'b0;
      w_state_nx  = (d != '0) ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_RUN: begin
          // step==0 needs no special case: q is nonzero in RUN, so q-0 just holds.
          if (sub) begin
            if (w_diff[WIDTH]) begin
              w_borrow_nx = 1'b1;
              w_state_nx  = S_DONE;
`ifdef DOWNCOUNT_SATURATE_EN
              w_q_nx      = '0;
`else
              w_q_nx      = w_diff[WIDTH-1:0];
`endif
            end else begin
              w_q_nx = w_diff[WIDTH-1:0];
              if (w_diff[WIDTH-1:0] == '0) w_state_nx = S_DONE;
            end
          end else if (en) begin
            w_q_nx = w_dec;
            if (w_dec == '0) w_state_nx = S_DONE;
          end
        end
        S_DONE:  w_state_nx = S_IDLE;
        S_IDLE:  w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= S_IDLE;
      r_q      <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_q      <= w_q_nx;
      r_borrow <= w_borrow_nx;
    end
  end

  assign q      = r_q;
  assign zero   = (r_q == '0);
  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign borrow = r_borrow;

endmodule
